// File: rtl/seq_divider16x8.sv
// rtl/seq_divider16x8.sv - sequential restoring divider, 16-bit dividend / 8-bit divisor
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   EH, EL, ED     load enables: a -> dividend[15:8], dividend[7:0], divisor
//   a              shared operand input bus
//   start          division request, sampled only in IDLE
//   busy           high while iterating (CALC)
//   done           one-cycle pulse when q/r/dz update
//   dz             divide-by-zero flag for the last operation
//   q, r           quotient and remainder registers
//   outled         display mux of the operand registers
module seq_divider16x8 #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          EH,
    input  logic          EL,
    input  logic          ED,
    input  logic [VW-1:0] a,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic [VW-1:0] outled
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] w;        // dividend shifting out the top, quotient bits in the bottom
    logic [VW:0]   rem;      // partial remainder, one bit wider than the divisor
    logic [CW-1:0] cnt;

    logic [VW:0]   trial;
    logic          fits;
    logic [VW:0]   rem_next;
    logic [DW-1:0] w_next;

    // One restoring step: bring down the next dividend bit and try to subtract.
    always_comb begin
        trial    = {rem[VW-1:0], w[DW-1]};
        fits     = (trial >= {1'b0, divisor});
        rem_next = fits ? (trial - {1'b0, divisor}) : trial;
        w_next   = {w[DW-2:0], fits};
    end

    always_comb begin
        outled = '0;
        case ({EH, EL, ED})
            3'b100:  outled = dividend[DW-1:DW-VW];
            3'b010:  outled = dividend[VW-1:0];
            3'b001:  outled = divisor;
            default: outled = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dividend <= '0;
            divisor  <= '0;
            w        <= '0;
            rem      <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dz       <= 1'b0;
        end else begin
            // Operands are frozen only while iterating.
            if (state != CALC) begin
                if (EH) dividend[DW-1:DW-VW] <= a;
                if (EL) dividend[VW-1:0]     <= a;
                if (ED) divisor              <= a;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            q     <= '1;
                            r     <= dividend[VW-1:0];
                            dz    <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            w     <= dividend;
                            rem   <= '0;
                            cnt   <= CW'(DW - 1);
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    w   <= w_next;
                    rem <= rem_next;
                    if (cnt == '0) begin
                        q     <= w_next;
                        r     <= rem_next[VW-1:0];
                        dz    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider16x8.sv
// tb/tb_seq_divider16x8.sv - self-checking bench for seq_divider16x8
module tb_seq_divider16x8;
    logic        clk = 1'b0;
    logic        rst, EH, EL, ED, start;
    logic [7:0]  a;
    logic        busy, done, dz;
    logic [15:0] q;
    logic [7:0]  r, outled;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] q;
        logic [7:0]  r;
        logic        dz;
    } result_t;

    result_t sb[$];

    logic [15:0] cur_dividend;
    logic [7:0]  cur_divisor;

    seq_divider16x8 dut (
        .clk(clk), .rst(rst), .EH(EH), .EL(EL), .ED(ED), .a(a),
        .start(start), .busy(busy), .done(done), .dz(dz),
        .q(q), .r(r), .outled(outled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] en, input logic [7:0] v);
        @(negedge clk);
        {EH, EL, ED} = en;
        a = v;
        @(negedge clk);
        {EH, EL, ED} = 3'b000;
        if (en[2]) cur_dividend[15:8] = v;
        if (en[1]) cur_dividend[7:0]  = v;
        if (en[0]) cur_divisor        = v;
    endtask

    task automatic set_ops(input logic [15:0] dd, input logic [7:0] dv);
        load(3'b100, dd[15:8]);
        load(3'b010, dd[7:0]);
        load(3'b001, dv);
    endtask

    task automatic push_expected();
        result_t e;
        if (cur_divisor == 8'h00) begin
            e.q = 16'hFFFF; e.r = cur_dividend[7:0]; e.dz = 1'b1;
        end else begin
            e.q = cur_dividend / cur_divisor;
            e.r = 8'(cur_dividend % cur_divisor);
            e.dz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Pulse start across one rising edge; returns at the negedge after acceptance.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        push_expected();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int k = 0; k <= 40; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    task automatic compare_result(input string tag);
        result_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_q"}, 32'(q), 32'(e.q));
        check({tag, "_r"}, 32'(r), 32'(e.r));
        check({tag, "_dz"}, 32'(dz), 32'(e.dz));
    endtask

    task automatic run_div(input string tag, input logic [15:0] dd, input logic [7:0] dv);
        int lat, bcnt;
        set_ops(dd, dv);
        pulse_start();
        wait_done(lat, bcnt);
        check({tag, "_latency"}, 32'(lat), 32'd16);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
        compare_result(tag);
    endtask

    task automatic outled_check(input string tag, input logic [2:0] en, input logic [7:0] exp);
        @(negedge clk);
        {EH, EL, ED} = en;
        #1;
        check(tag, 32'(outled), 32'(exp));
        {EH, EL, ED} = 3'b000;
    endtask

    initial begin
        int lat, bcnt, dc0;
        rst = 1'b1; EH = 0; EL = 0; ED = 0; start = 0; a = 8'h00;
        cur_dividend = 16'h0000; cur_divisor = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_q", 32'(q), 32'h0);
        check("reset_r", 32'(r), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_dz", 32'(dz), 32'h0);
        outled_check("reset_outled_div", 3'b001, 8'h00);

        run_div("d12345_100", 16'h3039, 8'h64);
        check("d12345_q_const", 32'(q), 32'h007B);
        check("d12345_r_const", 32'(r), 32'h2D);
        run_div("d1000_7", 16'h03E8, 8'h07);
        run_div("dffff_ff", 16'hFFFF, 8'hFF);
        load(3'b001, 8'h01);
        pulse_start();
        wait_done(lat, bcnt);
        check("dffff_01_latency", 32'(lat), 32'd16);
        compare_result("dffff_01");
        run_div("d0005_09", 16'h0005, 8'h09);

        // Divide by zero: immediate completion, no iteration.
        set_ops(16'h1234, 8'h00);
        pulse_start();
        wait_done(lat, bcnt);
        check("dz_latency", 32'(lat), 32'd0);
        check("dz_busy_never", 32'(bcnt), 32'd0);
        compare_result("dz");
        @(negedge clk);
        check("dz_done_one_cycle", 32'(done), 32'd0);

        // Loads and start while iterating must be ignored.
        set_ops(16'hABCD, 8'h11);
        dc0 = done_cnt;
        pulse_start();
        repeat (3) @(negedge clk);
        ED = 1'b1; a = 8'h03; start = 1'b1;
        @(negedge clk);
        ED = 1'b0; start = 1'b0;
        wait_done(lat, bcnt);
        check("busy_ignore_latency", 32'(lat - 12), 32'd0);
        compare_result("busy_ignore");
        repeat (20) @(negedge clk);
        check("busy_ignore_one_done", 32'(done_cnt - dc0), 32'd1);
        outled_check("busy_ignore_divisor", 3'b001, 8'h11);

        // Reset in the middle of iterating.
        set_ops(16'h4321, 8'h0D);
        dc0 = done_cnt;
        pulse_start();
        void'(sb.pop_back());
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cur_dividend = 16'h0000; cur_divisor = 8'h00;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_q", 32'(q), 32'h0);
        check("midrst_r", 32'(r), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        repeat (20) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
        run_div("after_rst", 16'h4321, 8'h0D);

        // Display mux.
        set_ops(16'h5AC3, 8'h27);
        outled_check("outled_hi", 3'b100, 8'h5A);
        outled_check("outled_lo", 3'b010, 8'hC3);
        outled_check("outled_div", 3'b001, 8'h27);
        outled_check("outled_hi_lo", 3'b110, 8'h00);
        outled_check("outled_all", 3'b111, 8'h00);

        // Back-to-back starts reuse the same operands.
        run_div("reuse_a", 16'h5AC3, 8'h27);
        pulse_start();
        wait_done(lat, bcnt);
        check("reuse_b_latency", 32'(lat), 32'd16);
        compare_result("reuse_b");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
